demultiplexador_registrado: RTL and testbench

- Registered 1-to-4 demultiplexer for the Bloco Operativo. It is the distribution counterpart of the registered 4-to-1 selector: one 16-bit source is steered into one of four destination holding registers.
- Each destination is a 1-deep buffer with a full flag and a per-channel acknowledge.
- The source side uses a valid/ready handshake.
- An optional broadcast input writes all four channels at once.

---
 rtl/demultiplexador_registrado.sv | 133 +++++++++++++
 tb/tb_demultiplexador_registrado.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/demultiplexador_registrado.sv
// demultiplexador_registrado
//
// Purpose:
//   Registered 1-to-4 demultiplexer for the Bloco Operativo. One WIDTH-bit
//   source word is steered into one of four destination holding registers
//   (saidaA..saidaD). Each destination behaves as a 1-deep buffer with a
//   full flag (cheio) and a per-channel release (ack). The source side uses
//   a valid/ready handshake. A broadcast request (todos) writes all four
//   channels at once. Accepted transfers are counted in a wrapping counter.
//
// Ports:
//   clk       in   system clock, all state updates on posedge
//   rst       in   synchronous reset, active-high
//   entrada   in   WIDTH  data to distribute
//   set       in   2      destination select (0=A, 1=B, 2=C, 3=D)
//   todos     in   1      broadcast request, overrides set
//   in_valid  in   1      source presents entrada/set/todos
//   in_ready  out  1      block can accept this cycle (combinational)
//   ack       in   4      per-channel release (bit0=A .. bit3=D)
//   saidaA..D out  WIDTH  channel holding registers
//   cheio     out  4      channel full flags
//   contador  out  CONT_W accepted-transfer counter
//
// Optional feature (macro DEMUX_PASSTHRU_EN):
//   When defined, an ack arriving in the same cycle as a write to that
//   channel frees the slot in time for the write, so a channel can accept
//   one word per cycle. The write wins: the register loads the new word
//   and the flag stays set. When undefined, a full channel must see its
//   ack first and can only be rewritten on a later cycle.

module demultiplexador_registrado #(
    parameter int WIDTH  = 16,
    parameter int CONT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  entrada,
    input  logic [1:0]        set,
    input  logic              todos,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        ack,
    output logic [WIDTH-1:0]  saidaA,
    output logic [WIDTH-1:0]  saidaB,
    output logic [WIDTH-1:0]  saidaC,
    output logic [WIDTH-1:0]  saidaD,
    output logic [3:0]        cheio,
    output logic [CONT_W-1:0] contador
);

    // Per-channel full state. Each bit is its own two-state machine.
    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } canalEstado_e;

    logic [3:0][WIDTH-1:0] saida_q, saida_d;
    logic [3:0]            cheio_q, cheio_d;
    logic [CONT_W-1:0]     contador_q, contador_d;

    logic [3:0]            writeMask;
    logic                  acceptXfer;

    // Readiness: a single write needs its target slot free; a broadcast needs
    // every slot free. With passthrough, a slot being released this cycle
    // counts as free.
    always_comb begin
        in_ready = 1'b0;
`ifdef DEMUX_PASSTHRU_EN
        if (todos) begin
            in_ready = &(~cheio_q | ack);
        end else begin
            in_ready = ~cheio_q[set] | ack[set];
        end
`else
        if (todos) begin
            in_ready = (cheio_q == 4'b0000);
        end else begin
            in_ready = (cheio_q[set] == VAZIO);
        end
`endif
    end

    // Which channels a transfer would load: all four on broadcast, otherwise
    // the one-hot decode of set.
    always_comb begin
        writeMask  = todos ? 4'b1111 : (4'b0001 << set);
        acceptXfer = in_valid && in_ready;
    end

    // Next state. Acks clear flags first and a write then sets its flags, so
    // a write to the same channel in the same cycle wins (this only happens
    // with passthrough; otherwise in_ready blocks it). Acks on empty channels
    // fall out harmlessly. Released data is kept, never cleared.
    always_comb begin
        saida_d    = saida_q;
        cheio_d    = cheio_q & ~ack;
        contador_d = contador_q;
        if (acceptXfer) begin
            cheio_d    = cheio_d | writeMask;
            contador_d = contador_q + {{(CONT_W-1){1'b0}}, 1'b1};
            for (int i = 0; i < 4; i++) begin
                if (writeMask[i]) begin
                    saida_d[i] = entrada;
                end
            end
        end
    end

    // State registers. Reset beats any transfer or ack in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            saida_q    <= '0;
            cheio_q    <= 4'b0000;
            contador_q <= '0;
        end else begin
            saida_q    <= saida_d;
            cheio_q    <= cheio_d;
            contador_q <= contador_d;
        end
    end

    // Output mapping from the internal channel array.
    always_comb begin
        saidaA   = saida_q[0];
        saidaB   = saida_q[1];
        saidaC   = saida_q[2];
        saidaD   = saida_q[3];
        cheio    = cheio_q;
        contador = contador_q;
    end

endmodule

// File: tb/tb_demultiplexador_registrado.sv
// tb_demultiplexador_registrado
//
// Directed bench for demultiplexador_registrado. A reference model of the
// channel buffers is advanced as each step is driven; its predicted state is
// queued and compared against the DUT after the clock edge. Hard-coded
// expectations from the test plan are checked on top of the model.

module tb_demultiplexador_registrado;

    localparam int WIDTH  = 16;
    localparam int CONT_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIDTH-1:0]  entrada;
    logic [1:0]        set;
    logic              todos;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        ack;
    logic [WIDTH-1:0]  saidaA, saidaB, saidaC, saidaD;
    logic [3:0]        cheio;
    logic [CONT_W-1:0] contador;

    typedef struct packed {
        logic [3:0][WIDTH-1:0] s;
        logic [3:0]            c;
        logic [CONT_W-1:0]     n;
    } snap_t;

    snap_t expQ[$];

    logic [3:0][WIDTH-1:0] mS;
    logic [3:0]            mC;
    logic [CONT_W-1:0]     mN;

    int assertCount = 0;
    int failCount   = 0;

    demultiplexador_registrado #(.WIDTH(WIDTH), .CONT_W(CONT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .entrada  (entrada),
        .set      (set),
        .todos    (todos),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ack      (ack),
        .saidaA   (saidaA),
        .saidaB   (saidaB),
        .saidaC   (saidaC),
        .saidaD   (saidaD),
        .cheio    (cheio),
        .contador (contador)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assertCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Readiness as the block's contract defines it, from the model's flags.
    function automatic logic modelReady(input logic todosV, input logic [1:0] setV, input logic [3:0] ackV);
`ifdef DEMUX_PASSTHRU_EN
        if (todosV) return &(~mC | ackV);
        return ~mC[setV] | ackV[setV];
`else
        if (todosV) return (mC == 4'b0000);
        return ~mC[setV];
`endif
    endfunction

    // Drive one cycle of stimulus on the falling edge, check in_ready, advance
    // the model, then compare the DUT against the queued prediction after the
    // rising edge.
    task automatic applyStimulus(input logic rstV, input logic validV, input logic todosV,
                                 input logic [1:0] setV, input logic [WIDTH-1:0] dataV,
                                 input logic [3:0] ackV, input string tag);
        snap_t e;
        logic  rdy;
        logic  acc;
        @(negedge clk);
        rst      = rstV;
        in_valid = validV;
        todos    = todosV;
        set      = setV;
        entrada  = dataV;
        ack      = ackV;
        #1;
        rdy = modelReady(todosV, setV, ackV);
        checkOutput({tag, ".in_ready"}, {31'b0, in_ready}, {31'b0, rdy});
        acc = validV && rdy;
        if (rstV) begin
            mS = '0;
            mC = 4'b0000;
            mN = '0;
        end else begin
            mC = mC & ~ackV;
            if (acc) begin
                if (todosV) begin
                    for (int i = 0; i < 4; i++) mS[i] = dataV;
                    mC = 4'b1111;
                end else begin
                    mS[setV] = dataV;
                    mC[setV] = 1'b1;
                end
                mN = mN + 1'b1;
            end
        end
        e.s = mS;
        e.c = mC;
        e.n = mN;
        expQ.push_back(e);
        @(posedge clk);
        #1;
        e = expQ.pop_front();
        checkOutput({tag, ".saidaA"},   {16'b0, saidaA},   {16'b0, e.s[0]});
        checkOutput({tag, ".saidaB"},   {16'b0, saidaB},   {16'b0, e.s[1]});
        checkOutput({tag, ".saidaC"},   {16'b0, saidaC},   {16'b0, e.s[2]});
        checkOutput({tag, ".saidaD"},   {16'b0, saidaD},   {16'b0, e.s[3]});
        checkOutput({tag, ".cheio"},    {28'b0, cheio},    {28'b0, e.c});
        checkOutput({tag, ".contador"}, {24'b0, contador}, {24'b0, e.n});
    endtask

    initial begin
        int nWrites;
        rst      = 1'b1;
        in_valid = 1'b0;
        todos    = 1'b0;
        set      = 2'd0;
        entrada  = '0;
        ack      = 4'b0000;
        mS       = '0;
        mC       = 4'b0000;
        mN       = '0;

        // 1. Reset, then write to channel B.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000, "rst0");
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000, "rst1");
        checkOutput("t1.resetCheio", {28'b0, cheio}, 32'h0);
        checkOutput("t1.resetCont",  {24'b0, contador}, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 16'h00AB, 4'b0000, "t1.wrB");
        checkOutput("t1.saidaB", {16'b0, saidaB}, 32'h00AB);
        checkOutput("t1.cheio",  {28'b0, cheio},  32'h2);
        checkOutput("t1.cont",   {24'b0, contador}, 32'h1);
        checkOutput("t1.saidaA", {16'b0, saidaA}, 32'h0);

        // 2. Write to full B is refused, then release B.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd1, 16'h1234, 4'b0000, "t2.wrFull");
        checkOutput("t2.saidaBheld", {16'b0, saidaB}, 32'h00AB);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd1, 16'h1234, 4'b0010, "t2.ackB");
        checkOutput("t2.cheio",     {28'b0, cheio},  32'h0);
        checkOutput("t2.saidaBkept", {16'b0, saidaB}, 32'h00AB);

        // 3. Broadcast gated by a full channel A.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 16'h00A0, 4'b0000, "t3.wrA");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'h5555, 4'b0000, "t3.bcBlocked");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'h5555, 4'b0001, "t3.bcAck");
        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'h5555, 4'b0000, "t3.bcRetry");
        checkOutput("t3.saidaD", {16'b0, saidaD}, 32'h5555);
        checkOutput("t3.cheio",  {28'b0, cheio},  32'hF);
        checkOutput("t3.cont",   {24'b0, contador}, 32'h3);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b1111, "t3.clear");

        // 4. Ack on A together with a write to D.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd0, 16'h00A1, 4'b0000, "t4.wrA");
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd3, 16'h00D0, 4'b0001, "t4.ackAwrD");
        checkOutput("t4.cheio",  {28'b0, cheio},  32'h8);
        checkOutput("t4.saidaD", {16'b0, saidaD}, 32'h00D0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b1000, "t4.clear");

        // 5. Ack and write hit full channel C in the same cycle.
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 16'h0CC0, 4'b0000, "t5.wrC");
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 16'h0C0C, 4'b0100, "t5.ackWrC");
`ifdef DEMUX_PASSTHRU_EN
        checkOutput("t5.cheioC", {31'b0, cheio[2]}, 32'h1);
        checkOutput("t5.saidaC", {16'b0, saidaC},   32'h0C0C);
`else
        checkOutput("t5.cheioC", {31'b0, cheio[2]}, 32'h0);
        checkOutput("t5.saidaC", {16'b0, saidaC},   32'h0CC0);
`endif
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b1111, "t5.clear");

        // 6. Drive the counter round to zero with one write per cycle,
        // rotating channels and acking everything so each target is free.
        nWrites = 256 - int'(mN);
        for (int i = 0; i < nWrites; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 2'(i % 4), 16'(i + 16'h0100), 4'b1111, "t6.wr");
        end
        checkOutput("t6.wrap", {24'b0, contador}, 32'h0);

        // Reset in the same cycle as an accepted write.
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b1111, "t6.clear");
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd1, 16'hBEEF, 4'b0000, "t6.rstWr");
        checkOutput("t6.rstCheio",  {28'b0, cheio},    32'h0);
        checkOutput("t6.rstCont",   {24'b0, contador}, 32'h0);
        checkOutput("t6.rstSaidaB", {16'b0, saidaB},   32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000, "t6.idle");

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
